systolic_mac_array: RTL and testbench



---
 rtl/matmul_pkg.sv | 24 ++
 rtl/mac_pe.sv | 44 ++++
 rtl/systolic_mac_array.sv | 138 +++++++++++++
 tb/tb_systolic_mac_array.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/matmul_pkg.sv
// Shared sizing, types and controller states for the systolic matrix-multiply grid.
package matmul_pkg;

  localparam int DEF_N      = 3;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_ACC_W  = 34;

  typedef logic signed [DEF_DATA_W-1:0] data_t;
  typedef logic signed [DEF_ACC_W-1:0]  acc_t;

  typedef enum logic [1:0] {
    IDLE,
    COMPUTE,
    DONE
  } state_t;

  // The cycle on which the operands reach the bottom-right PE for the last time.
  function automatic int last_t(input int n);
    return 3 * n - 3;
  endfunction

  localparam int LAST_T = last_t(DEF_N);

endpackage

// File: rtl/mac_pe.sv
// One output-stationary PE: registers A/B for its right/lower neighbours and accumulates A*B.
module mac_pe
  import matmul_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     load,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] a_in,
  input  logic signed [DATA_W-1:0] b_in,
  output logic signed [DATA_W-1:0] a_fwd,
  output logic signed [DATA_W-1:0] b_fwd,
  output logic signed [ACC_W-1:0]  acc_nxt
);

  logic signed [ACC_W-1:0]    acc;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [ACC_W-1:0]    prod_ext;

  assign prod     = (2*DATA_W)'(a_in) * (2*DATA_W)'(b_in);
  assign prod_ext = ACC_W'(prod);
  // Exposed so the top can capture the final sum on the same edge it is formed.
  assign acc_nxt  = acc + prod_ext;

  always_ff @(posedge clk) begin
    if (rst) begin
      a_fwd <= '0;
      b_fwd <= '0;
      acc   <= '0;
    end else if (clr) begin
      a_fwd <= '0;
      b_fwd <= '0;
    end else if (en) begin
      a_fwd <= a_in;
      b_fwd <= b_in;
      acc   <= load ? prod_ext : acc_nxt;
    end
  end

endmodule

// File: rtl/systolic_mac_array.sv
// N x N output-stationary MAC grid computing C = A*B from skewed row/column streams,
// with a frame controller that masks stale lanes and publishes C once per start.
//
//   state   | meaning
//   IDLE    | forward regs held at 0; start loads accumulators and begins a frame
//   COMPUTE | busy, every PE accumulates; t = counter
//   DONE    | one-cycle result_valid, forward regs cleared
module systolic_mac_array
  import matmul_pkg::*;
#(
  parameter int N      = DEF_N,
  parameter int DATA_W = DEF_DATA_W,
  parameter int ACC_W  = DEF_ACC_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [N*DATA_W-1:0]    row_in,
  input  logic [N*DATA_W-1:0]    col_in,
  output logic                   busy,
  output logic                   result_valid,
  output logic [N*N*ACC_W-1:0]   result
);

  localparam int                 CNT_W    = $clog2(3 * N);
  localparam logic [CNT_W-1:0]   LAST_CNT = CNT_W'(last_t(N));

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] t;
  logic             frame;
  logic             pe_load;

  logic signed [DATA_W-1:0] row_m [N];
  logic signed [DATA_W-1:0] col_m [N];
  logic signed [DATA_W-1:0] a_in_g  [N][N];
  logic signed [DATA_W-1:0] b_in_g  [N][N];
  logic signed [DATA_W-1:0] a_out_g [N][N];
  logic signed [DATA_W-1:0] b_out_g [N][N];
  logic signed [ACC_W-1:0]  acc_nxt_g [N][N];
  logic [N*N*ACC_W-1:0]     acc_all;

  // The start cycle itself is t=0 of the frame, so it counts as in-frame.
  assign frame   = (state == COMPUTE) || ((state == IDLE) && start);
  assign t       = (state == COMPUTE) ? counter : '0;
  assign pe_load = (state == IDLE);

  // Upstream holds its last value outside the window, so lanes are zeroed there.
  for (genvar g = 0; g < N; g++) begin : g_lane
    logic lane_on;
    assign lane_on  = frame && (int'(t) >= g) && (int'(t) <= g + N - 1);
    assign row_m[g] = lane_on ? row_in[g*DATA_W +: DATA_W] : '0;
    assign col_m[g] = lane_on ? col_in[g*DATA_W +: DATA_W] : '0;
  end

  for (genvar i = 0; i < N; i++) begin : g_row
    for (genvar j = 0; j < N; j++) begin : g_col
      if (j == 0) begin : g_a_edge
        assign a_in_g[i][j] = row_m[i];
      end else begin : g_a_chain
        assign a_in_g[i][j] = a_out_g[i][j-1];
      end
      if (i == 0) begin : g_b_edge
        assign b_in_g[i][j] = col_m[j];
      end else begin : g_b_chain
        assign b_in_g[i][j] = b_out_g[i-1][j];
      end

      mac_pe #(
        .DATA_W (DATA_W),
        .ACC_W  (ACC_W)
      ) u_pe (
        .clk     (clk),
        .rst     (rst),
        .en      (frame),
        .load    (pe_load),
        .clr     (!frame),
        .a_in    (a_in_g[i][j]),
        .b_in    (b_in_g[i][j]),
        .a_fwd   (a_out_g[i][j]),
        .b_fwd   (b_out_g[i][j]),
        .acc_nxt (acc_nxt_g[i][j])
      );
    end
  end

  always_comb begin
    acc_all = '0;
    for (int i = 0; i < N; i++) begin
      for (int j = 0; j < N; j++) begin
        acc_all[(i*N+j)*ACC_W +: ACC_W] = acc_nxt_g[i][j];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      counter      <= '0;
      busy         <= 1'b0;
      result_valid <= 1'b0;
      result       <= '0;
    end else begin
      case (state)
        IDLE: begin
          result_valid <= 1'b0;
          if (start) begin
            state   <= COMPUTE;
            counter <= CNT_W'(1);
            busy    <= 1'b1;
          end
        end
        COMPUTE: begin
          if (counter == LAST_CNT) begin
            state        <= DONE;
            counter      <= '0;
            busy         <= 1'b0;
            result_valid <= 1'b1;
            result       <= acc_all;
          end else begin
            counter <= counter + 1'b1;
          end
        end
        DONE: begin
          state        <= IDLE;
          result_valid <= 1'b0;
        end
        default: begin
          state        <= IDLE;
          counter      <= '0;
          busy         <= 1'b0;
          result_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_mac_array.sv
// Directed bench for systolic_mac_array: skewed 3x3 products with hand-computed C,
// stale-lane masking, start/reset interactions and back-to-back framing.
module tb_systolic_mac_array;

  localparam int N  = 3;
  localparam int DW = 16;
  localparam int AW = 34;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic [N*DW-1:0]      row_in;
  logic [N*DW-1:0]      col_in;
  logic                 busy;
  logic                 result_valid;
  logic [N*N*AW-1:0]    result;
  logic                 busy32;
  logic                 result_valid32;
  logic [N*N*32-1:0]    result32;

  always #5 clk = ~clk;

  systolic_mac_array #(.N(N), .DATA_W(DW), .ACC_W(AW)) u_dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .row_in       (row_in),
    .col_in       (col_in),
    .busy         (busy),
    .result_valid (result_valid),
    .result       (result)
  );

  systolic_mac_array #(.N(N), .DATA_W(DW), .ACC_W(32)) u_dut32 (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .row_in       (row_in),
    .col_in       (col_in),
    .busy         (busy32),
    .result_valid (result_valid32),
    .result       (result32)
  );

  int     n_cmp = 0;
  int     n_err = 0;
  int     ma [3][3];
  int     mb [3][3];
  int     ma2 [3][3];
  int     mb2 [3][3];
  longint exp_c [3][3];
  longint snap [3][3];
  int     row_hold [3];
  int     col_hold [3];
  int     first_valid_t;
  int     last_valid_t;
  int     valid_cnt;
  int     busy_bad;

  task automatic chk(input string tag, input longint obs, input longint exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint res34(input int i, input int j);
    logic signed [AW-1:0] v;
    v = result[(i*N+j)*AW +: AW];
    return longint'(v);
  endfunction

  function automatic longint res32(input int i, input int j);
    logic signed [31:0] v;
    v = result32[(i*N+j)*32 +: 32];
    return longint'(v);
  endfunction

  // Lane i carries A[i][k] / B[k][i] at t=k+i and holds its last value otherwise.
  task automatic drive_lanes(input int t, input int second_t);
    int tt;
    int k;
    bit sec;
    sec = (second_t >= 0) && (t >= second_t);
    tt  = sec ? t - second_t : t;
    for (int i = 0; i < 3; i++) begin
      k = tt - i;
      if (k >= 0 && k <= 2) begin
        row_hold[i] = sec ? ma2[i][k] : ma[i][k];
        col_hold[i] = sec ? mb2[k][i] : mb[k][i];
      end
      row_in[i*DW +: DW] = row_hold[i][15:0];
      col_in[i*DW +: DW] = col_hold[i][15:0];
    end
  endtask

  task automatic run_prod(input int n_cyc, input int second_t, input int extra_start_t,
                          input int rst_t, input int snap_t, input int busy_last);
    int tt;
    bit be;
    valid_cnt     = 0;
    first_valid_t = -1;
    last_valid_t  = -1;
    busy_bad      = 0;
    for (int i = 0; i < 3; i++) begin
      row_hold[i] = 77;
      col_hold[i] = -77;
    end
    for (int t = 0; t < n_cyc; t++) begin
      @(posedge clk);
      #1;
      drive_lanes(t, second_t);
      start = (t == 0) || (t == second_t) || (t == extra_start_t);
      rst   = (t == rst_t);
      @(negedge clk);
      tt = (second_t >= 0 && t >= second_t) ? t - second_t : t;
      be = (tt >= 1) && (tt <= busy_last);
      if (busy !== be) busy_bad++;
      if (result_valid === 1'b1) begin
        valid_cnt++;
        if (first_valid_t < 0) first_valid_t = t;
        last_valid_t = t;
      end
      if (t == snap_t) begin
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            snap[i][j] = res34(i, j);
      end
    end
    start = 1'b0;
    rst   = 1'b0;
  endtask

  task automatic check_c(input string name);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        chk($sformatf("%s_c%0d%0d", name, i, j), res34(i, j), exp_c[i][j]);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst    = 1'b1;
    start  = 1'b1;
    row_in = '0;
    col_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_valid", longint'(result_valid), 0);
    chk("rst_result_zero", longint'(result == '0), 1);
    #1;
    start = 1'b0;

    // Basic product
    ma    = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};
    mb    = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};
    exp_c = '{'{30, 36, 42}, '{66, 81, 96}, '{102, 126, 150}};
    run_prod(10, -1, -1, -1, -1, 6);
    chk("basic_valid_cnt", valid_cnt, 1);
    chk("basic_valid_t", first_valid_t, 7);
    chk("basic_busy_profile", busy_bad, 0);
    check_c("basic");

    // Identity A with stale lanes before/after the window
    ma    = '{'{1, 0, 0}, '{0, 1, 0}, '{0, 0, 1}};
    mb    = '{'{-5, 2, 0}, '{7, -1, 3}, '{9, 9, -9}};
    exp_c = '{'{-5, 2, 0}, '{7, -1, 3}, '{9, 9, -9}};
    run_prod(10, -1, -1, -1, -1, 6);
    chk("ident_valid_t", first_valid_t, 7);
    check_c("ident");

    // Extremes: 3 * 2^30 fits in 34 bits, wraps in 32 bits
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++) begin
        ma[i][j]    = -32768;
        mb[i][j]    = -32768;
        exp_c[i][j] = 64'sd3221225472;
      end
    run_prod(10, -1, -1, -1, -1, 6);
    check_c("extreme");
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        chk($sformatf("wrap32_c%0d%0d", i, j), res32(i, j), -64'sd1073741824);

    // Start while busy is ignored
    ma    = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};
    mb    = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};
    exp_c = '{'{30, 36, 42}, '{66, 81, 96}, '{102, 126, 150}};
    run_prod(14, -1, 3, -1, -1, 6);
    chk("busy_start_valid_cnt", valid_cnt, 1);
    chk("busy_start_valid_t", first_valid_t, 7);
    chk("busy_start_profile", busy_bad, 0);
    check_c("busy_start");

    // Reset in the middle of COMPUTE
    run_prod(10, -1, -1, 4, 5, 4);
    chk("abort_valid_cnt", valid_cnt, 0);
    chk("abort_busy_profile", busy_bad, 0);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        chk($sformatf("abort_zero_c%0d%0d", i, j), snap[i][j], 0);
    run_prod(10, -1, -1, -1, -1, 6);
    chk("after_abort_valid_t", first_valid_t, 7);
    check_c("after_abort");

    // Back-to-back: identity*B then a second, different product at t=8
    ma  = '{'{1, 0, 0}, '{0, 1, 0}, '{0, 0, 1}};
    mb  = '{'{-5, 2, 0}, '{7, -1, 3}, '{9, 9, -9}};
    ma2 = '{'{1, 0, -1}, '{2, 1, 0}, '{0, 0, 3}};
    mb2 = '{'{1, 2, 3}, '{4, 5, 6}, '{7, 8, 9}};
    run_prod(18, 8, -1, -1, 14, 6);
    chk("b2b_valid_cnt", valid_cnt, 2);
    chk("b2b_first_valid_t", first_valid_t, 7);
    chk("b2b_last_valid_t", last_valid_t, 15);
    chk("b2b_busy_profile", busy_bad, 0);
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        chk($sformatf("b2b_hold_c%0d%0d", i, j), snap[i][j], longint'(mb[i][j]));
    exp_c = '{'{-6, -6, -6}, '{6, 9, 12}, '{21, 24, 27}};
    check_c("b2b_second");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
